if_fetch: RTL and testbench
===========================

// Module: if_fetch
// PURPOSE
//  Instruction fetch stage for the RV64 core inside soc; sits between the PC and decode.
//  Generates the PC, drives the synchronous instruction ROM (rom_inst), and buffers the
//  returned 32-bit words in a 2-entry queue. Decode takes words through a valid/ready
//  handshake. A redirect from execute (jump/branch) flushes everything in flight.
// PARAMETERS
//  XLEN      64     PC / address width
//  INST_W    32     instruction word width
//  RESET_PC  64'h0  first fetch address after reset
// PORTS
//  clk           in   1       core clock; all state changes on posedge
//  rst           in   1       asynchronous, active-low reset
//  rom_req_o     out  1       ROM read strobe; data returns exactly 1 cycle later
//  rom_addr_o    out  XLEN    ROM byte address (bits [1:0] always 0)
//  rom_inst_i    in   INST_W  ROM read data, valid the cycle after rom_req_o
//  inst_valid_o  out  1       head of queue holds a valid instruction
//  inst_o        out  INST_W  instruction at queue head
//  inst_addr_o   out  XLEN    PC of inst_o
//  inst_ready_i  in   1       decode accepts head this cycle (transfer = valid & ready)
//  jump_en_i     in   1       redirect request from execute
//  jump_addr_i   in   XLEN    redirect target
// BEHAVIOUR
//  Reset (rst=0, async): pc=RESET_PC, queue empty, no read in flight, all outputs 0
//   (inst_valid_o=0, rom_req_o=0, rom_addr_o=0, inst_o=0, inst_addr_o=0).
//   The first rom_req_o is issued on the first cycle after rst deasserts.
//  Issue rule: rom_req_o=1 when (queue_count + inflight - pop) < 2 and jump_en_i=0.
//   Here pop = inst_valid_o & inst_ready_i.
//   On issue: rom_addr_o=pc, inflight<=1, pc<=pc+4 (wraps modulo 2^XLEN, no trap).
//  Return: the cycle after issue, if not stale, push {rom_inst_i, issued pc} into the queue.
//   The issue rule guarantees the push never overflows.
//  Latency: empty queue, ready held 1 -> inst_valid_o rises 2 cycles after rom_req_o.
//   Back-to-back steady state = 1 instruction per cycle.
//  Queue: 2-entry FIFO, head on inst_o/inst_addr_o, read pointer and write pointer 1 bit each.
//   Simultaneous push and pop at count=2 is legal; count stays 2.
//   Pop with count=0 is impossible (valid=0).
//  Stall: inst_ready_i=0 with valid=1 -> inst_o/inst_addr_o held stable, no new issue
//   once full.
//  Redirect (jump_en_i=1): that cycle rom_req_o=0, and any pop in that cycle still completes.
//   Next edge: queue cleared, pc <= {jump_addr_i[XLEN-1:2],2'b00}.
//   Any read in flight is marked stale and its data is discarded on return.
//   inst_valid_o=0 the cycle after; the first fetch at the target issues the cycle after.
//  Back-to-back redirects: the last one wins; stale tracking covers every dropped read.
//  Reset mid-operation clears inflight/stale and the queue immediately; nothing
//   survives reset.
// TESTING
//  1 Reset release, ready=1, ROM[0..3]=ADD words -> rom_addr_o 0,4,8,12 on consecutive
//    cycles. inst_valid_o first high cycle 2; inst_addr_o 0,4,8,12.
//  2 Ready low 5 cycles after first valid -> exactly 2 words buffered, rom_req_o=0,
//    inst_o stable. On release, words delivered in order, no gap, no duplicate.
//  3 jump_en_i with jump_addr_i=0x40 while queue full and a read in flight -> stale word
//    dropped. Next inst_addr_o = 0x40, no old PC seen afterwards.
//  4 Jump with jump_addr_i=0x43 -> rom_addr_o=0x40. Jump in the same cycle as a transfer
//    -> transferred word counted once.
//  5 RESET_PC=64'hFFFF_FFFF_FFFF_FFFC -> fetch FFFC then 0x0 (wrap). Async rst pulse
//    mid-burst -> outputs 0 without waiting for a clock edge.
//  6 Random ready/jump for 10k cycles vs. reference PC model -> delivered PC sequence
//    matches and the queue never overflows.

Source files
------------

// File: rtl/if_fetch.sv
// Instruction fetch stage: PC generation, synchronous ROM read issue, and a
// 2-entry instruction queue feeding decode over valid/ready. A redirect from
// execute flushes the queue and the read in flight.
module if_fetch #(
    parameter int               XLEN     = 64,
    parameter int               INST_W   = 32,
    parameter logic [XLEN-1:0]  RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    output logic              rom_req_o,
    output logic [XLEN-1:0]   rom_addr_o,
    input  logic [INST_W-1:0] rom_inst_i,
    output logic              inst_valid_o,
    output logic [INST_W-1:0] inst_o,
    output logic [XLEN-1:0]   inst_addr_o,
    input  logic              inst_ready_i,
    input  logic              jump_en_i,
    input  logic [XLEN-1:0]   jump_addr_i
);

    logic [XLEN-1:0]             pc_q, pc_d;
    logic [XLEN-1:0]             req_pc_q;
    logic                        inflight_q;
    logic [1:0]                  cnt_q, cnt_d;
    logic                        rptr_q, rptr_d;
    logic                        wptr_q, wptr_d;
    logic [1:0][INST_W-1:0]      qinst_q;
    logic [1:0][XLEN-1:0]        qaddr_q;

    logic       pop, push, issue;
    logic [1:0] occ;

    // The target's low bits are forced to zero, so they never reach state.
    logic unused_jump_lsb;
    assign unused_jump_lsb = ^jump_addr_i[1:0];

    assign inst_valid_o = (cnt_q != 2'd0);
    assign pop          = inst_valid_o & inst_ready_i;
    // Words the queue must still absorb next cycle: buffered plus returning, minus leaving.
    assign occ          = cnt_q + {1'b0, inflight_q} - {1'b0, pop};
    // rst gates the strobe so nothing is requested while reset is held.
    assign issue        = rst & ~jump_en_i & (occ < 2'd2);
    // A read in flight during a redirect returns in that same cycle, so
    // suppressing the push here is all it takes to discard the stale word.
    assign push         = inflight_q & ~jump_en_i;

    assign rom_req_o    = issue;
    assign rom_addr_o   = issue ? pc_q : '0;
    assign inst_o       = inst_valid_o ? qinst_q[rptr_q] : '0;
    assign inst_addr_o  = inst_valid_o ? qaddr_q[rptr_q] : '0;

    // Next-state for PC and queue bookkeeping; a redirect overrides everything.
    always_comb begin
        pc_d   = pc_q;
        cnt_d  = cnt_q + {1'b0, push} - {1'b0, pop};
        rptr_d = rptr_q ^ pop;
        wptr_d = wptr_q ^ push;
        if (jump_en_i) begin
            pc_d   = {jump_addr_i[XLEN-1:2], 2'b00};
            cnt_d  = 2'd0;
            rptr_d = 1'b0;
            wptr_d = 1'b0;
        end else if (issue) begin
            pc_d   = pc_q + XLEN'(4);
        end
    end

    // Control state: PC, read-in-flight tracking, queue pointers and count.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q       <= RESET_PC;
            req_pc_q   <= '0;
            inflight_q <= 1'b0;
            cnt_q      <= 2'd0;
            rptr_q     <= 1'b0;
            wptr_q     <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            inflight_q <= issue;
            cnt_q      <= cnt_d;
            rptr_q     <= rptr_d;
            wptr_q     <= wptr_d;
            if (issue) req_pc_q <= pc_q;
        end
    end

    // Queue storage: returning ROM word is written with the PC it was fetched from.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            qinst_q <= '0;
            qaddr_q <= '0;
        end else if (push) begin
            qinst_q[wptr_q] <= rom_inst_i;
            qaddr_q[wptr_q] <= req_pc_q;
        end
    end

endmodule

// File: tb/tb_if_fetch.sv
// Bench for if_fetch: directed scenarios plus a randomized ready/redirect run
// checked against a PC-sequence model of what decode should receive.
module tb_if_fetch;

    localparam int XLEN = 64;
    localparam int IW   = 32;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            rom_req;
    logic [XLEN-1:0] rom_addr;
    logic [IW-1:0]   rom_inst = '0;
    logic            valid;
    logic [IW-1:0]   inst;
    logic [XLEN-1:0] iaddr;
    logic            ready = 1'b0;
    logic            jump = 1'b0;
    logic [XLEN-1:0] jaddr = '0;

    logic            rst2 = 1'b0;
    logic            rom_req2;
    logic [XLEN-1:0] rom_addr2;
    logic [IW-1:0]   rom_inst2 = '0;
    logic            valid2;
    logic [IW-1:0]   inst2;
    logic [XLEN-1:0] iaddr2;
    logic            ready2 = 1'b1;
    logic            jump2 = 1'b0;
    logic [XLEN-1:0] jaddr2 = '0;

    int n_checks = 0;
    int n_fail   = 0;
    logic [XLEN-1:0] exp_next;

    always #5 clk = ~clk;

    function automatic logic [IW-1:0] rom_word(input logic [XLEN-1:0] a);
        return a[31:0] ^ a[63:32] ^ 32'h00A0_0033;
    endfunction

    // Synchronous ROM models: data appears the cycle after the strobe.
    always @(posedge clk) if (rom_req)  rom_inst  <= rom_word(rom_addr);
    always @(posedge clk) if (rom_req2) rom_inst2 <= rom_word(rom_addr2);

    if_fetch #(.XLEN(XLEN), .INST_W(IW), .RESET_PC(64'h0)) dut (
        .clk(clk), .rst(rst), .rom_req_o(rom_req), .rom_addr_o(rom_addr),
        .rom_inst_i(rom_inst), .inst_valid_o(valid), .inst_o(inst),
        .inst_addr_o(iaddr), .inst_ready_i(ready), .jump_en_i(jump),
        .jump_addr_i(jaddr));

    if_fetch #(.XLEN(XLEN), .INST_W(IW), .RESET_PC(64'hFFFF_FFFF_FFFF_FFFC)) dut2 (
        .clk(clk), .rst(rst2), .rom_req_o(rom_req2), .rom_addr_o(rom_addr2),
        .rom_inst_i(rom_inst2), .inst_valid_o(valid2), .inst_o(inst2),
        .inst_addr_o(iaddr2), .inst_ready_i(ready2), .jump_en_i(jump2),
        .jump_addr_i(jaddr2));

    task automatic test_reset();
        rst = 1'b0; ready = 1'b1; jump = 1'b0;
        #1;
        n_checks++; if (valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", valid); end
        n_checks++; if (rom_req !== 1'b0) begin n_fail++; $display("FAIL reset_req got %b want 0", rom_req); end
        n_checks++; if (rom_addr !== '0) begin n_fail++; $display("FAIL reset_addr got %h want 0", rom_addr); end
        n_checks++; if (inst !== '0) begin n_fail++; $display("FAIL reset_inst got %h want 0", inst); end
        n_checks++; if (iaddr !== '0) begin n_fail++; $display("FAIL reset_iaddr got %h want 0", iaddr); end
        @(posedge clk);
    endtask

    task automatic test_startup();
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (k == 0) rst = 1'b1;
            ready = 1'b1;
            #1;
            if (k < 4) begin
                n_checks++;
                if (rom_req !== 1'b1 || rom_addr !== XLEN'(4*k)) begin
                    n_fail++; $display("FAIL start_req c%0d got %b/%h want 1/%h", k, rom_req, rom_addr, 4*k);
                end
            end
            n_checks++;
            if (k < 2) begin
                if (valid !== 1'b0) begin n_fail++; $display("FAIL start_valid c%0d got %b want 0", k, valid); end
            end else if (valid !== 1'b1 || iaddr !== XLEN'(4*(k-2)) || inst !== rom_word(XLEN'(4*(k-2)))) begin
                n_fail++; $display("FAIL start_deliver c%0d got %b/%h/%h want 1/%h", k, valid, iaddr, inst, 4*(k-2));
            end
        end
        exp_next = 64'd16;
    endtask

    task automatic test_stall();
        for (int s = 0; s < 5; s++) begin
            @(negedge clk); ready = 1'b0; #1;
            n_checks++;
            if (valid !== 1'b1 || iaddr !== exp_next || inst !== rom_word(exp_next) || rom_req !== 1'b0) begin
                n_fail++; $display("FAIL stall c%0d got v%b a%h req%b want v1 a%h req0", s, valid, iaddr, rom_req, exp_next);
            end
        end
        for (int r = 0; r < 4; r++) begin
            @(negedge clk); ready = 1'b1; #1;
            n_checks++;
            if (valid !== 1'b1 || iaddr !== exp_next || inst !== rom_word(exp_next)) begin
                n_fail++; $display("FAIL stall_release c%0d got v%b a%h want v1 a%h", r, valid, iaddr, exp_next);
            end
            exp_next += 4;
        end
    endtask

    task automatic test_jump_full();
        @(negedge clk); ready = 1'b0; jump = 1'b1; jaddr = 64'h40; #1;
        n_checks++;
        if (rom_req !== 1'b0) begin n_fail++; $display("FAIL jump_req got %b want 0", rom_req); end
        for (int c = 0; c < 5; c++) begin
            @(negedge clk); ready = 1'b1; jump = 1'b0; #1;
            if (c == 0) begin
                n_checks++;
                if (rom_req !== 1'b1 || rom_addr !== 64'h40) begin
                    n_fail++; $display("FAIL jump_target_req got %b/%h want 1/40", rom_req, rom_addr);
                end
            end
            n_checks++;
            if (c < 2) begin
                if (valid !== 1'b0) begin n_fail++; $display("FAIL jump_gap c%0d got %b want 0", c, valid); end
            end else if (valid !== 1'b1 || iaddr !== XLEN'(64 + 4*(c-2))) begin
                n_fail++; $display("FAIL jump_deliver c%0d got v%b a%h want v1 a%h", c, valid, iaddr, 64 + 4*(c-2));
            end
        end
        exp_next = 64'h4C;
    endtask

    task automatic test_jump_xfer();
        @(negedge clk); ready = 1'b1; jump = 1'b1; jaddr = 64'h43; #1;
        n_checks++;
        if (valid !== 1'b1 || iaddr !== exp_next) begin
            n_fail++; $display("FAIL xfer_head got v%b a%h want v1 a%h", valid, iaddr, exp_next);
        end
        for (int c = 0; c < 4; c++) begin
            @(negedge clk); jump = 1'b0; #1;
            n_checks++;
            if (c == 0 && (rom_req !== 1'b1 || rom_addr !== 64'h40)) begin
                n_fail++; $display("FAIL xfer_align got %b/%h want 1/40", rom_req, rom_addr);
            end else if (c == 1 && valid !== 1'b0) begin
                n_fail++; $display("FAIL xfer_gap got %b want 0", valid);
            end else if (c >= 2 && (valid !== 1'b1 || iaddr !== XLEN'(64 + 4*(c-2)))) begin
                n_fail++; $display("FAIL xfer_deliver c%0d got v%b a%h want v1 a%h", c, valid, iaddr, 64 + 4*(c-2));
            end
        end
    endtask

    task automatic test_async_reset();
        @(negedge clk); ready = 1'b1; #1;
        n_checks++;
        if (valid !== 1'b1) begin n_fail++; $display("FAIL areset_pre got %b want 1", valid); end
        #2 rst = 1'b0;
        #1;
        n_checks++;
        if (valid !== 1'b0 || rom_req !== 1'b0 || rom_addr !== '0 || inst !== '0 || iaddr !== '0) begin
            n_fail++; $display("FAIL areset_outputs got v%b r%b a%h i%h ia%h want all 0", valid, rom_req, rom_addr, inst, iaddr);
        end
        @(negedge clk); rst = 1'b1; #1;
        n_checks++;
        if (rom_req !== 1'b1 || rom_addr !== '0 || valid !== 1'b0) begin
            n_fail++; $display("FAIL areset_restart got r%b a%h v%b want 1/0/0", rom_req, rom_addr, valid);
        end
    endtask

    task automatic test_wrap();
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (c == 0) rst2 = 1'b1;
            #1;
            n_checks++;
            if (c == 0 && (rom_req2 !== 1'b1 || rom_addr2 !== 64'hFFFF_FFFF_FFFF_FFFC)) begin
                n_fail++; $display("FAIL wrap_req0 got %b/%h want 1/fffffffffffffffc", rom_req2, rom_addr2);
            end else if (c == 1 && (rom_req2 !== 1'b1 || rom_addr2 !== 64'h0)) begin
                n_fail++; $display("FAIL wrap_req1 got %b/%h want 1/0", rom_req2, rom_addr2);
            end else if (c == 2 && (valid2 !== 1'b1 || iaddr2 !== 64'hFFFF_FFFF_FFFF_FFFC ||
                                    inst2 !== rom_word(64'hFFFF_FFFF_FFFF_FFFC))) begin
                n_fail++; $display("FAIL wrap_del0 got v%b a%h want v1 a fffffffffffffffc", valid2, iaddr2);
            end else if (c == 3 && (valid2 !== 1'b1 || iaddr2 !== 64'h0)) begin
                n_fail++; $display("FAIL wrap_del1 got v%b a%h want v1 a0", valid2, iaddr2);
            end
        end
    endtask

    task automatic test_random();
        logic [XLEN-1:0] exp_pc;
        int occ, gap, delivered;
        @(negedge clk); rst = 1'b0; jump = 1'b0;
        @(negedge clk); rst = 1'b1;
        exp_pc = '0; occ = 0; gap = 0; delivered = 0;
        for (int i = 0; i < 10000; i++) begin
            if (i > 0) @(negedge clk);
            ready = ($urandom_range(0, 3) != 0);
            jump  = ($urandom_range(0, 19) == 0);
            jaddr = {$urandom, $urandom};
            #1;
            if (jump) begin
                n_checks++;
                if (rom_req !== 1'b0) begin n_fail++; $display("FAIL rnd_jump_req c%0d got %b want 0", i, rom_req); end
            end
            if (rom_req) begin
                n_checks++;
                if (rom_addr[1:0] !== 2'b00) begin n_fail++; $display("FAIL rnd_align c%0d got %h", i, rom_addr); end
            end
            if (valid) begin
                n_checks++;
                if (iaddr !== exp_pc || inst !== rom_word(exp_pc)) begin
                    n_fail++; $display("FAIL rnd_head c%0d got a%h i%h want a%h i%h", i, iaddr, inst, exp_pc, rom_word(exp_pc));
                end
            end
            if (valid && ready) begin exp_pc += 4; delivered++; end
            if (jump) begin
                exp_pc = {jaddr[XLEN-1:2], 2'b00};
                occ = 0; gap = 0;
            end else begin
                occ = occ + int'(rom_req) - int'(valid && ready);
                gap = valid ? 0 : gap + 1;
            end
            n_checks++;
            if (occ > 2 || gap > 2) begin
                n_fail++; $display("FAIL rnd_occupancy c%0d got occ%0d gap%0d want occ<=2 gap<=2", i, occ, gap);
            end
        end
        n_checks++;
        if (delivered < 1000) begin n_fail++; $display("FAIL rnd_throughput got %0d want >=1000", delivered); end
        @(negedge clk); jump = 1'b0;
    endtask

    initial begin
        test_reset();
        test_startup();
        test_stall();
        test_jump_full();
        test_jump_xfer();
        test_async_reset();
        test_wrap();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
